// File: rtl/counter_reader.sv
// Snapshots two live counters on a request and streams the snapshot out as WORD_W words over valid/ready.
// Optional: define COUNTER_READER_CSUM_EN to append an XOR checksum word to every frame.
module counter_reader #(
   parameter int unsigned CNT_W  = 64,
   parameter int unsigned WORD_W = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [CNT_W-1:0]  Count0,
   input  logic [CNT_W-1:0]  Count1,
   input  logic              Req,
   input  logic              Ready,
   output logic [WORD_W-1:0] Dout,
   output logic              Valid,
   output logic              Last,
   output logic              Busy,
   output logic              Overrun
);

   localparam int unsigned NWORDS = 2 * CNT_W / WORD_W;
`ifdef COUNTER_READER_CSUM_EN
   localparam int unsigned FRAME_LEN = NWORDS + 1;
`else
   localparam int unsigned FRAME_LEN = NWORDS;
`endif
   localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   typedef enum logic {IDLE, SEND} state_e;

   state_e              state_q;
   logic [2*CNT_W-1:0]  snap_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    idx_d;
   logic [WORD_W-1:0]   dout_q;
   logic [WORD_W-1:0]   word_d;
   logic                valid_q;
   logic                last_q;
   logic                busy_q;
   logic                overrun_q;
`ifdef COUNTER_READER_CSUM_EN
   logic [WORD_W-1:0]   csum_q;
`endif

   // Next word index and the snapshot slice it selects; indices past the data words select zero
   always_comb begin
      idx_d  = idx_q + IDX_W'(1);
      word_d = '0;
      for (int unsigned i = 0; i < NWORDS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            word_d = snap_q[i*WORD_W +: WORD_W];
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         snap_q    <= '0;
         idx_q     <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
`ifdef COUNTER_READER_CSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         overrun_q <= 1'b0;
         if (state_q == IDLE) begin
            if (Req) begin
               state_q <= SEND;
               snap_q  <= {Count1, Count0};
               idx_q   <= '0;
               dout_q  <= Count0[WORD_W-1:0];
               valid_q <= 1'b1;
               last_q  <= 1'b0;
               busy_q  <= 1'b1;
`ifdef COUNTER_READER_CSUM_EN
               csum_q  <= Count0[WORD_W-1:0];
`endif
            end
         end else begin
            // Any request while a frame is in flight is dropped and flagged
            overrun_q <= Req;
            if (valid_q && Ready) begin
               if (last_q) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  busy_q  <= 1'b0;
               end else begin
                  idx_q  <= idx_d;
                  last_q <= (idx_d == IDX_W'(FRAME_LEN - 1));
`ifdef COUNTER_READER_CSUM_EN
                  if (idx_d == IDX_W'(NWORDS)) begin
                     dout_q <= csum_q;
                  end else begin
                     dout_q <= word_d;
                     csum_q <= csum_q ^ word_d;
                  end
`else
                  dout_q <= word_d;
`endif
               end
            end
         end
      end
   end

   assign Dout    = dout_q;
   assign Valid   = valid_q;
   assign Last    = last_q;
   assign Busy    = busy_q;
   assign Overrun = overrun_q;

endmodule

// File: tb/tb_counter_reader.sv
// Self-checking bench for counter_reader: random counters and ready patterns against a word-list model.
module tb_counter_reader;

   localparam int unsigned CNT_W  = 64;
   localparam int unsigned WORD_W = 16;
   localparam int NWORDS = 2 * CNT_W / WORD_W;
`ifdef COUNTER_READER_CSUM_EN
   localparam int FRAME_LEN = NWORDS + 1;
`else
   localparam int FRAME_LEN = NWORDS;
`endif

   logic              Clk = 1'b0;
   logic              Reset;
   logic [CNT_W-1:0]  Count0;
   logic [CNT_W-1:0]  Count1;
   logic              Req;
   logic              Ready;
   logic [WORD_W-1:0] Dout;
   logic              Valid;
   logic              Last;
   logic              Busy;
   logic              Overrun;

   counter_reader #(.CNT_W(CNT_W), .WORD_W(WORD_W)) dut (
      .Clk(Clk), .Reset(Reset), .Count0(Count0), .Count1(Count1), .Req(Req), .Ready(Ready),
      .Dout(Dout), .Valid(Valid), .Last(Last), .Busy(Busy), .Overrun(Overrun)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2*CNT_W-1:0] exp_snap;
   logic [WORD_W-1:0]  got[$];
   int  last_pos, last_cnt, stall_err, ovr_cnt, cyc;
   bit  timed_out;
   logic first_valid, first_busy;

   // Expected word i of a frame: snapshot slices LSB first, then the XOR of all data slices
   function automatic logic [WORD_W-1:0] model_word(input logic [2*CNT_W-1:0] s, input int i);
      logic [WORD_W-1:0] x;
      x = '0;
      if (i < NWORDS) return WORD_W'(s >> (i * WORD_W));
      for (int k = 0; k < NWORDS; k++) x ^= WORD_W'(s >> (k * WORD_W));
      return x;
   endfunction

   function automatic int word_errs(input logic [2*CNT_W-1:0] s);
      int e;
      e = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== model_word(s, i)) e++;
      return e;
   endfunction

   // Issue one Req and consume the frame, recording transfers, stalls and overrun pulses
   task automatic run_frame(input int stall_at, input int stall_len, input bit rand_rdy,
                            input bit inc0, input int req_word, input bit req_last);
      int scnt;
      bit rdy, prev_stall;
      logic [WORD_W-1:0] prev_d;
      got.delete();
      last_pos = -1; last_cnt = 0; stall_err = 0; ovr_cnt = 0; cyc = 0; timed_out = 0;
      scnt = 0; prev_stall = 0; prev_d = '0;
      @(negedge Clk);
      Req = 1'b1; Ready = 1'b0;
      exp_snap = {Count1, Count0};
      @(negedge Clk);
      Req = 1'b0;
      first_valid = Valid;
      first_busy  = Busy;
      while (1) begin
         if (cyc > 300) begin timed_out = 1; break; end
         if (Overrun === 1'b1) ovr_cnt++;
         if (prev_stall && (Dout !== prev_d || Valid !== 1'b1)) stall_err++;
         if (Valid !== 1'b1) break;
         Req = 1'b0;
         if (stall_at >= 0 && got.size() == stall_at && scnt < stall_len) begin
            rdy = 1'b0; scnt++;
         end else if (rand_rdy) rdy = 1'($urandom_range(0, 1));
         else rdy = 1'b1;
         Ready = rdy;
         if (rdy && req_word >= 0 && got.size() == req_word) Req = 1'b1;
         if (rdy && req_last && Last === 1'b1) Req = 1'b1;
         if (rdy) begin
            if (Last === 1'b1) begin last_pos = got.size(); last_cnt++; end
            got.push_back(Dout);
         end
         prev_stall = !rdy;
         prev_d = Dout;
         if (inc0) Count0 = Count0 + 1;
         @(negedge Clk);
         cyc++;
      end
      Req = 1'b0; Ready = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b0; Req = 1'b0; Ready = 1'b0; Count0 = '0; Count1 = '0;
      #1;
      n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", Valid); end
      n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", Busy); end
      n_checks++; if (Last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", Last); end
      n_checks++; if (Overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", Overrun); end
      n_checks++; if (Dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", Dout); end
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      n_checks++; if (Valid !== 1'b0 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset valid %b busy %b exp 0 0", Valid, Busy);
      end
   endtask

   task automatic test_basic();
      Count0 = 64'h0123_4567_89AB_CDEF;
      Count1 = 64'hFEDC_BA98_7654_3210;
      run_frame(-1, 0, 0, 0, -1, 0);
      n_checks++; if (first_valid !== 1'b1 || first_busy !== 1'b1) begin
         n_fail++; $display("FAIL basic_first_valid valid %b busy %b exp 1 1", first_valid, first_busy);
      end
      n_checks++; if (got.size() !== FRAME_LEN) begin
         n_fail++; $display("FAIL basic_len got %0d exp %0d", got.size(), FRAME_LEN);
      end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== model_word(exp_snap, i)) begin
            n_fail++; $display("FAIL basic_word%0d got %h exp %h", i, got[i], model_word(exp_snap, i));
         end
      end
      n_checks++; if (got.size() > 7 && got[7] !== 16'hFEDC) begin
         n_fail++; $display("FAIL basic_word7_const got %h exp FEDC", got[7]);
      end
      n_checks++; if (last_pos !== FRAME_LEN - 1 || last_cnt !== 1) begin
         n_fail++; $display("FAIL basic_last pos %0d cnt %0d exp %0d 1", last_pos, last_cnt, FRAME_LEN - 1);
      end
      n_checks++; if (cyc !== FRAME_LEN || timed_out) begin
         n_fail++; $display("FAIL basic_cycles got %0d exp %0d", cyc, FRAME_LEN);
      end
      n_checks++; if (Busy !== 1'b0 || Last !== 1'b0) begin
         n_fail++; $display("FAIL basic_busy_after busy %b last %b exp 0 0", Busy, Last);
      end
   endtask

   task automatic test_backpressure();
      Count0 = 64'h0123_4567_89AB_CDEF;
      Count1 = 64'hFEDC_BA98_7654_3210;
      run_frame(2, 5, 0, 0, -1, 0);
      n_checks++; if (stall_err !== 0) begin
         n_fail++; $display("FAIL bp_stable got %0d stall errors exp 0", stall_err);
      end
      n_checks++; if (got.size() !== FRAME_LEN || word_errs(exp_snap) !== 0) begin
         n_fail++; $display("FAIL bp_words len %0d errs %0d exp %0d 0", got.size(), word_errs(exp_snap), FRAME_LEN);
      end
      n_checks++; if (got.size() > 2 && got[2] !== 16'h4567) begin
         n_fail++; $display("FAIL bp_word2 got %h exp 4567", got[2]);
      end
      n_checks++; if (cyc !== FRAME_LEN + 5) begin
         n_fail++; $display("FAIL bp_cycles got %0d exp %0d", cyc, FRAME_LEN + 5);
      end
   endtask

   task automatic test_atomic();
      Count0 = {$urandom, $urandom};
      Count1 = {$urandom, $urandom};
      run_frame(-1, 0, 1, 1, -1, 0);
      n_checks++; if (got.size() !== FRAME_LEN || word_errs(exp_snap) !== 0 || timed_out) begin
         n_fail++; $display("FAIL atomic_words len %0d errs %0d exp %0d 0", got.size(), word_errs(exp_snap), FRAME_LEN);
      end
      n_checks++; if (stall_err !== 0) begin
         n_fail++; $display("FAIL atomic_stable got %0d exp 0", stall_err);
      end
   endtask

   task automatic test_overrun();
      int extra;
      Count0 = {$urandom, $urandom};
      Count1 = {$urandom, $urandom};
      run_frame(-1, 0, 0, 0, 3, 1);
      n_checks++; if (ovr_cnt !== 2) begin
         n_fail++; $display("FAIL overrun_pulses got %0d exp 2", ovr_cnt);
      end
      n_checks++; if (got.size() !== FRAME_LEN || word_errs(exp_snap) !== 0) begin
         n_fail++; $display("FAIL overrun_words len %0d errs %0d exp %0d 0", got.size(), word_errs(exp_snap), FRAME_LEN);
      end
      extra = 0;
      Ready = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         if (Valid !== 1'b0 || Busy !== 1'b0 || Overrun !== 1'b0) extra++;
      end
      Ready = 1'b0;
      n_checks++; if (extra !== 0) begin
         n_fail++; $display("FAIL overrun_no_second_frame got %0d active cycles exp 0", extra);
      end
   endtask

   task automatic test_reset_midframe();
      Count0 = {$urandom, $urandom};
      Count1 = {$urandom, $urandom};
      @(negedge Clk);
      Req = 1'b1;
      exp_snap = {Count1, Count0};
      @(negedge Clk);
      Req = 1'b0; Ready = 1'b1;
      repeat (5) @(negedge Clk);
      n_checks++; if (Dout !== model_word(exp_snap, 5) || Valid !== 1'b1) begin
         n_fail++; $display("FAIL midreset_word5 got %h v%b exp %h v1", Dout, Valid, model_word(exp_snap, 5));
      end
      #2 Reset = 1'b0;
      #1;
      n_checks++; if (Valid !== 1'b0 || Busy !== 1'b0 || Last !== 1'b0 || Dout !== '0) begin
         n_fail++; $display("FAIL midreset_async v%b b%b l%b d%h exp 0 0 0 0", Valid, Busy, Last, Dout);
      end
      @(negedge Clk);
      Reset = 1'b1; Ready = 1'b0;
      @(negedge Clk);
      n_checks++; if (Valid !== 1'b0 || Busy !== 1'b0) begin
         n_fail++; $display("FAIL midreset_no_resume v%b b%b exp 0 0", Valid, Busy);
      end
      Count0 = {$urandom, $urandom};
      run_frame(-1, 0, 0, 0, -1, 0);
      n_checks++; if (got.size() !== FRAME_LEN || word_errs(exp_snap) !== 0 || last_pos !== FRAME_LEN - 1) begin
         n_fail++; $display("FAIL midreset_new_frame len %0d errs %0d last %0d exp %0d 0 %0d",
                            got.size(), word_errs(exp_snap), last_pos, FRAME_LEN, FRAME_LEN - 1);
      end
   endtask

   task automatic test_random();
      for (int f = 0; f < 6; f++) begin
         Count0 = {$urandom, $urandom};
         Count1 = {$urandom, $urandom};
         run_frame(-1, 0, 1, 1'($urandom_range(0, 1)), -1, 0);
         n_checks++;
         if (got.size() !== FRAME_LEN || word_errs(exp_snap) !== 0 || last_pos !== FRAME_LEN - 1 ||
             last_cnt !== 1 || stall_err !== 0 || ovr_cnt !== 0 || timed_out) begin
            n_fail++;
            $display("FAIL random_frame%0d len %0d errs %0d last %0d/%0d stall %0d ovr %0d exp %0d 0 %0d/1 0 0",
                     f, got.size(), word_errs(exp_snap), last_pos, last_cnt, stall_err, ovr_cnt,
                     FRAME_LEN, FRAME_LEN - 1);
         end
      end
   endtask

`ifdef COUNTER_READER_CSUM_EN
   task automatic test_csum();
      Count0 = 64'h0123_4567_89AB_CDEF;
      Count1 = 64'h1;
      run_frame(-1, 0, 0, 0, -1, 0);
      n_checks++; if (got.size() !== 9) begin
         n_fail++; $display("FAIL csum_len got %0d exp 9", got.size());
      end
      n_checks++; if (got.size() == 9 && got[8] !== 16'h0001) begin
         n_fail++; $display("FAIL csum_word got %h exp 0001", got[8]);
      end
      n_checks++; if (last_pos !== 8 || last_cnt !== 1) begin
         n_fail++; $display("FAIL csum_last pos %0d cnt %0d exp 8 1", last_pos, last_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_atomic();
      test_overrun();
      test_reset_midframe();
      test_random();
`ifdef COUNTER_READER_CSUM_EN
      test_csum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
